aes_block_packer: RTL and testbench

Upstream feeder for the AES top level. It accepts a 32-bit word stream using a valid/ready handshake and packs four words into one 128-bit plaintext block. Blocks are issued to the AES top one at a time: a single-cycle start pulse, a stable plaintext and key ROM address, and a wait for done. A two-slot structure (assembly register plus issue register) lets the next block fill while the current block encrypts.

---
 rtl/aes_block_packer_if.sv | 32 +++
 rtl/aes_block_packer.sv | 137 +++++++++++++
 tb/tb_aes_block_packer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_packer_if.sv
// Word-stream and AES-issue signals of the block packer.
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready are both 1;
// in_ready depends only on packer state, and the upstream holds in_data/in_last/in_key_addr while in_valid is 1.
interface aes_block_packer_if #(
    parameter int WORD_W  = 32,
    parameter int AES_LEN = 128,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic [ADDR_W-1:0]  in_key_addr;
    logic               start;
    logic [AES_LEN-1:0] plaintext;
    logic [ADDR_W-1:0]  key_addr;
    logic               done;
    logic               pad_flag;
    logic               busy;
    logic [CNT_W-1:0]   blk_cnt;

    modport slave (
        input  in_valid, in_data, in_last, in_key_addr, done,
        output in_ready, start, plaintext, key_addr, pad_flag, busy, blk_cnt
    );

    modport master (
        output in_valid, in_data, in_last, in_key_addr, done,
        input  in_ready, start, plaintext, key_addr, pad_flag, busy, blk_cnt
    );
endinterface

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into 128-bit blocks and issues them to the AES top one at a time.
// AES_LEN must equal 4*WORD_W; the assembly slot fills while the issue slot waits for done.
module aes_block_packer #(
    parameter int WORD_W  = 32,
    parameter int AES_LEN = 128,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    aes_block_packer_if.slave     bus,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [AES_LEN-1:0] asm_q;
    logic               asm_full_q;
    logic               asm_pad_q;
    logic [1:0]         word_idx_q;
    logic               first_q;
    logic [ADDR_W-1:0]  msg_key_q;

    logic [AES_LEN-1:0] pt_q;
    logic [ADDR_W-1:0]  key_q;
    logic               pad_q;
    logic [CNT_W-1:0]   cnt_q;

    logic accept;
    logic close_blk;
    logic slot_free;
    logic xfer;

    assign accept    = bus.in_valid & ~asm_full_q;
    assign close_blk = bus.in_last | (word_idx_q == 2'd3);
    assign slot_free = (state_q == IDLE) | ((state_q == WAIT) & bus.done);
    assign xfer      = asm_full_q & slot_free;

    // Assembly slot: accepts never coincide with a transfer because in_ready is low while full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            asm_q      <= '0;
            asm_full_q <= 1'b0;
            asm_pad_q  <= 1'b0;
            word_idx_q <= 2'd0;
            first_q    <= 1'b1;
            msg_key_q  <= '0;
        end else if (xfer) begin
            asm_q      <= '0;
            asm_full_q <= 1'b0;
            asm_pad_q  <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (word_idx_q == 2'(i)) begin
                    asm_q[(3-i)*WORD_W +: WORD_W] <= bus.in_data;
                end
            end
            if (first_q) begin
                msg_key_q <= bus.in_key_addr;
            end
            first_q <= bus.in_last;
            if (close_blk) begin
                asm_full_q <= 1'b1;
                asm_pad_q  <= (word_idx_q != 2'd3);
                word_idx_q <= 2'd0;
            end else begin
                word_idx_q <= word_idx_q + 2'd1;
            end
        end
    end

    // Issue slot holds its contents from the transfer edge until the next transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pt_q  <= '0;
            key_q <= '0;
            pad_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (xfer) begin
                pt_q  <= asm_q;
                key_q <= msg_key_q;
                pad_q <= asm_pad_q;
            end
            if (state_q == START) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // done outside WAIT is ignored: IDLE and START never look at it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.done) begin
                    state_d = xfer ? START : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = ~asm_full_q;
    assign bus.start     = (state_q == START);
    assign bus.busy      = (state_q != IDLE);
    assign bus.plaintext = pt_q;
    assign bus.key_addr  = key_q;
    assign bus.pad_flag  = pad_q;
    assign bus.blk_cnt   = cnt_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: vector table of single blocks plus hand-written
// sequences for back-pressure, reset mid-operation, counter wrap and ignored done pulses.
module tb_aes_block_packer;

    localparam int WORD_W  = 32;
    localparam int AES_LEN = 128;
    localparam int ADDR_W  = 5;
    // Narrow counter so the wrap is reachable in a short run.
    localparam int CNT_W   = 8;
    localparam int EXP_W   = AES_LEN + ADDR_W + 1;

    typedef struct {
        logic [WORD_W-1:0]  w [4];
        int                 n;
        logic               last;
        logic [ADDR_W-1:0]  key_in;
        logic [AES_LEN-1:0] exp_pt;
        logic [ADDR_W-1:0]  exp_key;
        logic               exp_pad;
    } vec_t;

    logic clk;
    logic nrst;
    logic [1:0] state_dbg;
    logic resp_done;
    logic man_done;
    logic auto_done;
    int   done_delay;
    int   cd;
    int   cyc;
    int   checks;
    int   errors;
    logic [CNT_W-1:0] exp_cnt;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] held;
    int   start_cycs[$];
    int   done_cycs[$];
    vec_t vec [7];

    aes_block_packer_if #(.WORD_W(WORD_W), .AES_LEN(AES_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    aes_block_packer #(.WORD_W(WORD_W), .AES_LEN(AES_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    assign bus.done = resp_done | man_done;

    // Clock and cycle count (cyc = number of rising edges so far)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.done) done_cycs.push_back(cyc + 1);

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // AES-top responder: done pulses done_delay cycles after a start is seen
    initial begin
        resp_done = 1'b0;
        cd = 0;
        forever begin
            @(negedge clk);
            if (cd > 0) begin
                cd--;
                resp_done = (cd == 0);
            end else begin
                resp_done = 1'b0;
            end
            if (bus.start && auto_done) cd = done_delay;
        end
    end

    // Scoreboard: every start pops one expected block; issue outputs must hold while busy
    always @(negedge clk) begin
        if (bus.start) begin
            start_cycs.push_back(cyc);
            held = {bus.plaintext, bus.key_addr, bus.pad_flag};
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                check("block", {bus.plaintext, bus.key_addr, bus.pad_flag}, exp_q.pop_front());
            end
        end else if (bus.busy) begin
            check("stable", {bus.plaintext, bus.key_addr, bus.pad_flag}, held);
        end
    end

    // Driver tasks
    task automatic send_word(input logic [WORD_W-1:0] d, input logic last,
                             input logic [ADDR_W-1:0] k, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_data     = d;
        bus.in_last     = last;
        bus.in_key_addr = k;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n >= 500, 0);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.in_key_addr = ~k;
    endtask

    task automatic send_row(input int r, output int last_acc);
        for (int i = 0; i < vec[r].n; i++) begin
            send_word(vec[r].w[i], vec[r].last && (i == vec[r].n - 1),
                      (i == 0) ? vec[r].key_in : vec[r].key_in + 5'd1, last_acc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", bus.busy, 0);
    endtask

    task automatic set_vec(input int r, input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                           input logic [WORD_W-1:0] w2, input logic [WORD_W-1:0] w3,
                           input int n, input logic last, input logic [ADDR_W-1:0] key_in,
                           input logic [AES_LEN-1:0] exp_pt, input logic [ADDR_W-1:0] exp_key,
                           input logic exp_pad);
        vec[r].w[0] = w0; vec[r].w[1] = w1; vec[r].w[2] = w2; vec[r].w[3] = w3;
        vec[r].n = n; vec[r].last = last; vec[r].key_in = key_in;
        vec[r].exp_pt = exp_pt; vec[r].exp_key = exp_key; vec[r].exp_pad = exp_pad;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_start"}, bus.start, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_pad"}, bus.pad_flag, 0);
        check({tag, "_plaintext"}, bus.plaintext, 0);
        check({tag, "_key_addr"}, bus.key_addr, 0);
        check({tag, "_blk_cnt"}, bus.blk_cnt, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        int acc;
        int accs[12];
        int n;
        logic [WORD_W-1:0] w;

        cyc = 0; checks = 0; errors = 0; exp_cnt = '0;
        nrst = 1'b0; man_done = 1'b0; auto_done = 1'b1; done_delay = 1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_key_addr = '0;

        // Row: words, count, in_last on final word, key, expected plaintext/key/pad
        set_vec(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 4, 1'b1, 5'd3,
                128'h00112233_44556677_8899AABB_CCDDEEFF, 5'd3, 1'b0);
        set_vec(1, 32'hDEADBEEF, 32'h01020304, 32'h0, 32'h0, 2, 1'b1, 5'd5,
                128'hDEADBEEF_01020304_00000000_00000000, 5'd5, 1'b1);
        set_vec(2, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 1, 1'b1, 5'd1,
                128'hA5A5A5A5_00000000_00000000_00000000, 5'd1, 1'b1);
        set_vec(3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 1'b0, 5'd7,
                128'h11111111_22222222_33333333_44444444, 5'd7, 1'b0);
        set_vec(4, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 4, 1'b1, 5'd9,
                128'h55555555_66666666_77777777_88888888, 5'd7, 1'b0);
        set_vec(5, 32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0, 4, 1'b1, 5'd12,
                128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0, 5'd12, 1'b0);
        set_vec(6, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h0, 3, 1'b1, 5'd31,
                128'hFFFFFFFF_80000001_7FFFFFFE_00000000, 5'd31, 1'b1);

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Table: single blocks, padding, key per message, start latency and in_ready timing
        for (int r = 0; r < 7; r++) begin
            start_cycs.delete();
            exp_q.push_back({vec[r].exp_pt, vec[r].exp_key, vec[r].exp_pad});
            send_row(r, acc);
            check("ready_low_after_close", bus.in_ready, 0);
            @(posedge clk);
            #1;
            check("ready_back_after_xfer", bus.in_ready, 1);
            wait_idle();
            check("start_count", start_cycs.size(), 1);
            check("start_latency", start_cycs[0], acc + 1);
            exp_cnt++;
            check("blk_cnt_table", bus.blk_cnt, exp_cnt);
        end

        // Back-pressure: 12 words in one message, done 20 cycles after each start
        start_cycs.delete();
        done_cycs.delete();
        done_delay = 20;
        exp_q.push_back({128'h10000000_10000001_10000002_10000003, 5'd4, 1'b0});
        exp_q.push_back({128'h10000004_10000005_10000006_10000007, 5'd4, 1'b0});
        exp_q.push_back({128'h10000008_10000009_1000000A_1000000B, 5'd4, 1'b0});
        for (int i = 0; i < 12; i++) begin
            send_word(32'h10000000 + i, i == 11, (i == 0) ? 5'd4 : 5'd20, accs[i]);
        end
        wait_idle();
        check("bp_word5_after_xfer", accs[4], start_cycs[0] + 1);
        check("bp_words5to8_streamed", accs[7], accs[4] + 3);
        check("bp_word9_after_done", accs[8], done_cycs[0] + 1);
        check("bp_start2_on_done", start_cycs[1], done_cycs[0]);
        check("bp_start3_on_done", start_cycs[2], done_cycs[1]);
        exp_cnt = exp_cnt + 3;
        check("bp_blk_cnt", bus.blk_cnt, exp_cnt);
        done_delay = 1;

        // Reset while WAIT holds a block and the assembly slot is full; done in START ignored
        start_cycs.delete();
        auto_done = 1'b0;
        exp_q.push_back({128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003, 5'd6, 1'b0});
        for (int i = 0; i < 4; i++) send_word(32'hAAAA0000 + i, i == 3, 5'd6, acc);
        n = 0;
        while (!bus.start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_start_seen", bus.start, 1);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        check("done_in_start_ignored", state_dbg, 2);
        for (int i = 0; i < 4; i++) send_word(32'hBBBB0000 + i, i == 3, 5'd8, acc);
        repeat (3) @(negedge clk);
        check("rst_asm_full", bus.in_ready, 0);
        check("rst_waiting", state_dbg, 2);
        nrst = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        check("no_start_after_reset", start_cycs.size(), 1);
        exp_cnt = '0;
        auto_done = 1'b1;
        exp_q.push_back({128'h01234567_89ABCDEF_FEDCBA98_76543210, 5'd2, 1'b0});
        send_word(32'h01234567, 1'b0, 5'd2, acc);
        send_word(32'h89ABCDEF, 1'b0, 5'd9, acc);
        send_word(32'hFEDCBA98, 1'b0, 5'd9, acc);
        send_word(32'h76543210, 1'b1, 5'd9, acc);
        wait_idle();
        exp_cnt++;
        check("rst_fresh_blk_cnt", bus.blk_cnt, exp_cnt);

        // Counter wrap with one-word padded blocks, then done pulses while idle
        while (exp_cnt != 8'd255) begin
            w = 32'hC0DE0000 + 32'(exp_cnt);
            exp_q.push_back({w, 96'h0, exp_cnt[4:0], 1'b1});
            send_word(w, 1'b1, exp_cnt[4:0], acc);
            exp_cnt++;
        end
        wait_idle();
        check("cnt_max", bus.blk_cnt, 8'd255);
        exp_q.push_back({32'hC0DEFFFF, 96'h0, 5'd30, 1'b1});
        send_word(32'hC0DEFFFF, 1'b1, 5'd30, acc);
        wait_idle();
        check("cnt_wrap", bus.blk_cnt, 0);

        n = start_cycs.size();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            man_done = 1'b1;
            @(negedge clk);
            man_done = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("idle_done_state", state_dbg, 0);
        check("idle_done_busy", bus.busy, 0);
        check("idle_done_no_start", start_cycs.size(), n);
        check("idle_done_cnt", bus.blk_cnt, 0);
        check("idle_done_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
